// File: rtl/regression_accumulator.sv
// Accumulates n, sum x, sum y, sum x*y and sum x*x over alternating x/y words
// fetched from a reader stage; sums freeze with `done` until the next start.
module regression_accumulator #(
  parameter int DW = 7,
  parameter int NW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          captured_data,
  input  logic                   dataFinish,
  output logic                   getData,
  output logic                   rewind,
  output logic                   busy,
  output logic                   done,
  output logic                   odd_tail,
  output logic                   overflow,
  output logic [NW-1:0]          n,
  output logic [DW+NW-1:0]       sum_x,
  output logic [DW+NW-1:0]       sum_y,
  output logic [2*DW+NW-1:0]     sum_xy,
  output logic [2*DW+NW-1:0]     sum_xx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ_X = 3'd2,
    CAP_X = 3'd3,
    REQ_Y = 3'd4,
    CAP_Y = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state;
  logic [DW-1:0]      x_reg;
  logic [2*DW-1:0]    prod_xy;
  logic [2*DW-1:0]    prod_xx;

  // Products are formed directly from the live y word during CAP_Y.
  always_comb begin
    prod_xy = {{DW{1'b0}}, x_reg} * {{DW{1'b0}}, captured_data};
    prod_xx = {{DW{1'b0}}, x_reg} * {{DW{1'b0}}, x_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_reg    <= {DW{1'b0}};
      getData  <= 1'b0;
      rewind   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      odd_tail <= 1'b0;
      overflow <= 1'b0;
      n        <= {NW{1'b0}};
      sum_x    <= {(DW+NW){1'b0}};
      sum_y    <= {(DW+NW){1'b0}};
      sum_xy   <= {(2*DW+NW){1'b0}};
      sum_xx   <= {(2*DW+NW){1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            rewind   <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            odd_tail <= 1'b0;
            overflow <= 1'b0;
            n        <= {NW{1'b0}};
            sum_x    <= {(DW+NW){1'b0}};
            sum_y    <= {(DW+NW){1'b0}};
            sum_xy   <= {(2*DW+NW){1'b0}};
            sum_xx   <= {(2*DW+NW){1'b0}};
          end else begin
            state <= state;
          end
        end
        LOAD: begin
          state   <= REQ_X;
          rewind  <= 1'b0;
          getData <= 1'b1;
        end
        REQ_X: begin
          state   <= CAP_X;
          getData <= 1'b0;
        end
        CAP_X: begin
          x_reg <= captured_data;
          if (dataFinish) begin
            state    <= DONE;
            odd_tail <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            state   <= REQ_Y;
            getData <= 1'b1;
          end
        end
        REQ_Y: begin
          state   <= CAP_Y;
          getData <= 1'b0;
        end
        CAP_Y: begin
          if (n == {NW{1'b1}}) begin
            // Pair count is saturated: drop this pair and end the pass.
            state    <= DONE;
            overflow <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            n      <= n + {{(NW-1){1'b0}}, 1'b1};
            sum_x  <= sum_x + {{NW{1'b0}}, x_reg};
            sum_y  <= sum_y + {{NW{1'b0}}, captured_data};
            sum_xy <= sum_xy + {{NW{1'b0}}, prod_xy};
            sum_xx <= sum_xx + {{NW{1'b0}}, prod_xx};
            if (dataFinish) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= REQ_X;
              getData <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          getData <= 1'b0;
          rewind  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regression_accumulator.sv
// Scoreboard bench: expected sums queued at start, compared when done rises;
// a behavioural reader model supplies words on getData and restarts on rewind.
module tb_regression_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;

  logic [6:0] mem [0:15];
  int         len = 0;

  // reader models, one per DUT instance
  logic [6:0] rd0_data = 7'd0, rd1_data = 7'd0;
  logic       rd0_fin = 1'b0, rd1_fin = 1'b0;
  int         ptr0 = 0, ptr1 = 0;

  logic        gd0, rw0, busy0, done0, odd0, ovf0;
  logic [9:0]  n0;
  logic [16:0] sx0, sy0;
  logic [23:0] sxy0, sxx0;

  logic        gd1, rw1, busy1, done1, odd1, ovf1;
  logic [1:0]  n1;
  logic [8:0]  sx1, sy1;
  logic [15:0] sxy1, sxx1;

  regression_accumulator #(.DW(7), .NW(10)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .captured_data(rd0_data), .dataFinish(rd0_fin),
    .getData(gd0), .rewind(rw0), .busy(busy0), .done(done0), .odd_tail(odd0), .overflow(ovf0),
    .n(n0), .sum_x(sx0), .sum_y(sy0), .sum_xy(sxy0), .sum_xx(sxx0));

  regression_accumulator #(.DW(7), .NW(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .captured_data(rd1_data), .dataFinish(rd1_fin),
    .getData(gd1), .rewind(rw1), .busy(busy1), .done(done1), .odd_tail(odd1), .overflow(ovf1),
    .n(n1), .sum_x(sx1), .sum_y(sy1), .sum_xy(sxy1), .sum_xx(sxx1));

  always @(posedge clk) begin
    if (rw0) ptr0 <= 0;
    else if (gd0) begin
      rd0_data <= mem[ptr0];
      rd0_fin  <= (ptr0 == len - 1);
      ptr0     <= ptr0 + 1;
    end
    if (rw1) ptr1 <= 0;
    else if (gd1) begin
      rd1_data <= mem[ptr1];
      rd1_fin  <= (ptr1 == len - 1);
      ptr1     <= ptr1 + 1;
    end
  end

  typedef struct {
    logic [31:0] n, sx, sy, sxy, sxx;
    logic        odd, ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  bit   conflict = 1'b0;
  logic done0_d = 1'b0, done1_d = 1'b0;

  // Scoreboard: pop an expectation on every rising done and compare the frozen sums.
  always @(negedge clk) begin
    exp_t e;
    logic [161:0] got, want;
    if ((gd0 && rw0) || (gd1 && rw1)) conflict = 1'b1;
    if (done0 && !done0_d) begin
      checks = checks + 1;
      if (q0.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb0_unexpected_done: done rose with no pass expected");
      end else begin
        e = q0.pop_front();
        got  = {32'(n0), 32'(sx0), 32'(sy0), 32'(sxy0), 32'(sxx0), odd0, ovf0};
        want = {e.n, e.sx, e.sy, e.sxy, e.sxx, e.odd, e.ovf};
        if (got !== want) begin
          failures = failures + 1;
          $display("FAIL sb0_sums: got n=%0d sx=%0d sy=%0d sxy=%0d sxx=%0d odd=%b ovf=%b want n=%0d sx=%0d sy=%0d sxy=%0d sxx=%0d odd=%b ovf=%b",
                   n0, sx0, sy0, sxy0, sxx0, odd0, ovf0, e.n, e.sx, e.sy, e.sxy, e.sxx, e.odd, e.ovf);
        end
      end
    end
    if (done1 && !done1_d) begin
      checks = checks + 1;
      if (q1.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb1_unexpected_done: done rose with no pass expected");
      end else begin
        e = q1.pop_front();
        got  = {32'(n1), 32'(sx1), 32'(sy1), 32'(sxy1), 32'(sxx1), odd1, ovf1};
        want = {e.n, e.sx, e.sy, e.sxy, e.sxx, e.odd, e.ovf};
        if (got !== want) begin
          failures = failures + 1;
          $display("FAIL sb1_sums: got n=%0d sx=%0d sy=%0d sxy=%0d sxx=%0d odd=%b ovf=%b want n=%0d sx=%0d sy=%0d sxy=%0d sxx=%0d odd=%b ovf=%b",
                   n1, sx1, sy1, sxy1, sxx1, odd1, ovf1, e.n, e.sx, e.sy, e.sxy, e.sxx, e.odd, e.ovf);
        end
      end
    end
    done0_d = done0;
    done1_d = done1;
  end

  function automatic exp_t mk(int nn, int sx, int sy, int sxy, int sxx, bit odd, bit ovf);
    exp_t e;
    e.n = nn; e.sx = sx; e.sy = sy; e.sxy = sxy; e.sxx = sxx; e.odd = odd; e.ovf = ovf;
    return e;
  endfunction

  task automatic load_seq(input int first, input int count);
    for (int i = 0; i < count; i++) mem[i] = 7'(first + i);
    len = count;
  endtask

  // Drives one start pulse (plus an optional extra pulse at cycle poke) and
  // reports the cycle of the first rewind, first getData and done.
  task automatic run_pass(input bit sel, input int poke, output int lat,
                          output int rew_cyc, output int gd_cyc);
    lat = 0; rew_cyc = 0; gd_cyc = 0;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (sel) start1 = (cyc == poke); else start0 = (cyc == poke);
      if (rew_cyc == 0 && (sel ? rw1 : rw0)) rew_cyc = cyc;
      if (gd_cyc == 0 && (sel ? gd1 : gd0)) gd_cyc = cyc;
      if (sel ? done1 : done0) begin
        lat = cyc;
        break;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if ({gd0, rw0, busy0, done0, odd0, ovf0, n0, sx0, sy0, sxy0, sxx0} !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got done=%b busy=%b n=%0d sx=%0d sxy=%0d want all zero",
               done0, busy0, n0, sx0, sxy0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, rc, gc;
    load_seq(1, 6);
    q0.push_back(mk(3, 9, 12, 44, 35, 1'b0, 1'b0));
    run_pass(1'b0, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 14 || rc !== 1 || gc !== 2) begin
      failures = failures + 1;
      $display("FAIL basic_timing: got done=%0d rewind=%0d getData=%0d want 14 1 2", lat, rc, gc);
    end
  endtask

  task automatic test_odd_tail();
    int lat, rc, gc;
    load_seq(1, 5);
    mem[4] = 7'd9;
    q0.push_back(mk(2, 4, 6, 14, 10, 1'b1, 1'b0));
    run_pass(1'b0, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 12) begin
      failures = failures + 1;
      $display("FAIL odd_tail_latency: got %0d want 12", lat);
    end
  endtask

  task automatic test_max_pair();
    int lat, rc, gc;
    mem[0] = 7'd127; mem[1] = 7'd127; len = 2;
    q0.push_back(mk(1, 127, 127, 16129, 16129, 1'b0, 1'b0));
    run_pass(1'b0, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 6) begin
      failures = failures + 1;
      $display("FAIL max_pair_latency: got %0d want 6", lat);
    end
  endtask

  task automatic test_empty();
    int lat, rc, gc;
    mem[0] = 7'd5; len = 1;
    q0.push_back(mk(0, 0, 0, 0, 0, 1'b1, 1'b0));
    run_pass(1'b0, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 4) begin
      failures = failures + 1;
      $display("FAIL empty_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_overflow();
    int lat, rc, gc;
    load_seq(1, 8);
    q1.push_back(mk(3, 9, 12, 44, 35, 1'b0, 1'b1));
    run_pass(1'b1, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 18) begin
      failures = failures + 1;
      $display("FAIL overflow_latency: got %0d want 18", lat);
    end
  endtask

  task automatic test_rst_mid();
    int gcount, lat, rc, gc;
    bit seen_gd;
    load_seq(1, 6);
    gcount = 0;
    @(negedge clk);
    start0 = 1'b1;
    for (int cyc = 0; cyc < 40 && gcount < 4; cyc++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (gd0) gcount++;
    end
    checks = checks + 1;
    if (gcount !== 4) begin
      failures = failures + 1;
      $display("FAIL rst_mid_reach: got %0d getData pulses want 4", gcount);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks = checks + 1;
    if ({gd0, rw0, busy0, done0, odd0, ovf0, n0, sx0, sy0, sxy0, sxx0} !== '0) begin
      failures = failures + 1;
      $display("FAIL rst_mid_clear: got busy=%b n=%0d sx=%0d sy=%0d sxy=%0d want all zero",
               busy0, n0, sx0, sy0, sxy0);
    end
    seen_gd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (gd0 || done0) seen_gd = 1'b1;
    end
    checks = checks + 1;
    if (seen_gd !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL rst_mid_quiet: got activity=%b want 0", seen_gd);
    end
    q0.push_back(mk(3, 9, 12, 44, 35, 1'b0, 1'b0));
    run_pass(1'b0, 0, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 14 || rc !== 1) begin
      failures = failures + 1;
      $display("FAIL rst_mid_rerun: got done=%0d rewind=%0d want 14 1", lat, rc);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rc, gc;
    load_seq(2, 6);
    for (int k = 0; k < 2; k++) begin
      // pairs (2,3),(4,5),(6,7)
      q0.push_back(mk(3, 12, 15, 68, 56, 1'b0, 1'b0));
      run_pass(1'b0, 0, lat, rc, gc);
      checks = checks + 1;
      if (lat !== 14) begin
        failures = failures + 1;
        $display("FAIL back_to_back_latency: pass %0d got %0d want 14", k, lat);
      end
    end
  endtask

  task automatic test_start_busy();
    int lat, rc, gc;
    load_seq(2, 6);
    q0.push_back(mk(3, 12, 15, 68, 56, 1'b0, 1'b0));
    run_pass(1'b0, 5, lat, rc, gc);
    checks = checks + 1;
    if (lat !== 14) begin
      failures = failures + 1;
      $display("FAIL start_busy_latency: got %0d want 14", lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_tail();
    test_max_pair();
    test_empty();
    test_overflow();
    test_rst_mid();
    test_back_to_back();
    test_start_busy();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (q0.size() !== 0 || q1.size() !== 0) begin
      failures = failures + 1;
      $display("FAIL sb_drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    checks = checks + 1;
    if (conflict !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL getdata_rewind_overlap: got %b want 0", conflict);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
